adder_tree_scheduler: RTL and testbench
=======================================

# adder_tree_scheduler

- Shares one pipelined 8-operand, 4-bit adder tree between `NUM_REQ` requesters.
- Arbitrates requests round-robin and drives the tree's operand and valid inputs.
- Carries a requester-ID tag alongside each in-flight sum and routes each returning sum to its owner.
- Sits directly in front of the adder tree and provides a flush/drain mode for clean reconfiguration.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (2..4).
- `LATENCY`, 3, cycles from `tree_vi` high to the matching `tree_valid` high.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester request.
- `req_data` in 32*NUM_REQ: per-requester operands; requester i occupies bits [32i+31:32i], with val0 in the low nibble.
- `req_ready` out NUM_REQ: one-hot grant (combinational).
- `tree_vals` out 32: registered operands to the tree (val0..val7).
- `tree_vi` out 1: registered valid to the tree.
- `tree_sum` in 7: tree result.
- `tree_valid` in 1: tree result valid.
- `resp_valid` out NUM_REQ: one-hot, registered, one-cycle pulse.
- `resp_sum` out 7: registered sum, shared by all requesters.
- `flush_req` in 1: level input; requests a drain.
- `flush_done` out 1: high while the block is drained and held.
- `err` out 1: sticky tag/valid mismatch flag.

## Operation
State machine:
- RUN (reset state) → DRAIN when `flush_req`=1.
- DRAIN → HOLD when the tag pipeline is empty.
- HOLD → RUN when `flush_req`=0.

Grant rules:
- In RUN, `req_ready` grants exactly one requester with `req_valid`=1, chosen round-robin.
- Search starts at `rr_ptr`, then `rr_ptr+1`, and wraps modulo `NUM_REQ`.
- No grant is issued in DRAIN or HOLD.

Handshake:
- A transfer occurs when `req_valid[i] & req_ready[i]`.
- A requester holds `req_data` stable while `req_valid` is high and not yet granted.
- At most one transfer per cycle.

On a transfer:
- Next cycle: `tree_vals` = the granted slice, `tree_vi`=1, `rr_ptr` = granted index + 1 (wrapping).
- Otherwise `tree_vi`=0 and `tree_vals` holds its previous value.

Tag pipeline:
- Depth `LATENCY`; each entry is {valid, id}.
- Shifts every cycle; the head entry is loaded with the `tree_vi`/ID of the current tree issue.

Response:
- When the tail entry is valid and `tree_valid`=1: next cycle `resp_sum`=`tree_sum` and `resp_valid[id]`=1.
- `resp_sum` holds its value otherwise.

Error:
- Tail valid and `tree_valid` disagree → `err` set; it is cleared only by reset.
- No response is produced for an unmatched `tree_valid`.

Arithmetic:
- The block performs no arithmetic on data.
- The maximum sum is 8×15=120, which fits in 7 bits.

## Timing
Reset values (all outputs):
- `req_ready`=0, `tree_vals`=0, `tree_vi`=0, `resp_valid`=0, `resp_sum`=0, `flush_done`=0, `err`=0.
- `rr_ptr`=0, tag pipeline empty, state RUN.

Latency:
- Handshake cycle T → `tree_vi` at T+1 → `tree_valid` at T+1+LATENCY → `resp_valid` at T+2+LATENCY.

Throughput and back-pressure:
- Throughput is one request per cycle.
- There is no back-pressure on responses; the consumer always accepts.

Flush:
- A `flush_req` rising in the same cycle as a pending request blocks that grant, because the state check uses the current state and `flush_req`.
- `flush_done` asserts in the first HOLD cycle.
- Drain time is at most LATENCY+1 cycles.

Reset mid-operation:
- In-flight tags are discarded.
- The tree shares `rst_n`, so no stale result returns.

Single requester active:
- Receives a grant every cycle.

## Configuration
- `SCHED_FIXED_PRIO_EN` defined: the grant is fixed-priority, with the lowest index winning; `rr_ptr` is not implemented.
- Undefined (default): round-robin as specified above.

## Test plan
- Requester 0 alone, operands 0,5,6,7,8,9,2,2 → `tree_vi` one cycle after the handshake; `resp_valid`=01 with `resp_sum`=39 at LATENCY+2 cycles after the handshake.
- Both requesters held valid (r0 all 3s, r1 all 15s) for 4 cycles → grants alternate 01,10,01,10; responses alternate 24,120,24,120 with matching one-hot IDs.
- With `SCHED_FIXED_PRIO_EN` and the same stimulus → all 4 grants go to r0; r1 is granted only after r0 drops `req_valid`.
- `flush_req`=1 with 3 requests in flight → no new grants; 3 responses delivered; `flush_done`=1 within LATENCY+1 cycles; releasing `flush_req` resumes grants.
- Force `tree_valid`=1 with an empty tag pipeline → `err`=1 and stays set; no `resp_valid`; `rst_n`=0 clears it.
- Assert `rst_n`=0 mid-stream with 2 requests in flight → all outputs read 0 asynchronously; no response after reset release.

Source files
------------

// File: rtl/adder_tree_scheduler.sv
// adder_tree_scheduler: shares one pipelined 8-operand, 4-bit adder tree between NUM_REQ
// requesters. It issues one request per cycle, tags each issue with the requester ID,
// routes returning sums back to their owner, and offers a flush/drain/hold mode.
// Optional feature: define SCHED_FIXED_PRIO_EN for fixed-priority (lowest index wins)
// arbitration instead of round-robin.
module adder_tree_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            tree_vals,
  output logic                   tree_vi,
  input  logic [6:0]             tree_sum,
  input  logic                   tree_valid,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [6:0]             resp_sum,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic                   err
);

  localparam int unsigned IdW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {StRun, StDrain, StHold} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     gnt_idx;
  logic               gnt_any;
  logic               grant_en;
  logic               fire;
  logic [31:0]        tree_vals_q;
  logic               tree_vi_q;
  logic [IdW-1:0]     issue_id_q;
  logic [LATENCY-1:0] tag_vld_q;
  logic [IdW-1:0]     tag_id_q [LATENCY];
  logic               tail_vld;
  logic [IdW-1:0]     tail_id;
  logic               pipe_empty;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [6:0]         resp_sum_q;
  logic               err_q;

`ifdef SCHED_FIXED_PRIO_EN
  // Fixed priority: scan downwards so the lowest requesting index is the last to win.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IdW'(i);
      end
    end
  end
`else
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  int             cand;

  // Round-robin: scan offsets downwards so the candidate closest to rr_ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= int'(NUM_REQ)) cand -= int'(NUM_REQ);
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = IdW'(cand);
      end
    end
  end

  // Pointer moves to one past the last winner, wrapping at NUM_REQ.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fire) rr_ptr_d = (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Grants only in RUN with no flush pending this cycle; held at zero during reset.
  assign grant_en = rst_n && (state_q == StRun) && !flush_req;
  assign fire     = grant_en && gnt_any;

  // One-hot grant decode.
  always_comb begin
    req_ready = '0;
    if (fire) req_ready[gnt_idx] = 1'b1;
  end

  // Tree issue register: operands hold their last value when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_vals_q <= '0;
      tree_vi_q   <= 1'b0;
      issue_id_q  <= '0;
    end else begin
      tree_vi_q <= fire;
      if (fire) begin
        tree_vals_q <= req_data[32*gnt_idx +: 32];
        issue_id_q  <= gnt_idx;
      end
    end
  end

  // Tag pipeline tracks {valid, id} in step with the tree's internal stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) tag_id_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= tree_vi_q;
      tag_id_q[0]  <= issue_id_q;
      for (int i = 1; i < int'(LATENCY); i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign tail_vld   = tag_vld_q[LATENCY-1];
  assign tail_id    = tag_id_q[LATENCY-1];
  // An issue still sitting in the tree_vi register counts as in flight.
  assign pipe_empty = !tree_vi_q && (tag_vld_q == '0);

  // Response routing and sticky mismatch detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= '0;
      resp_sum_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      if (tail_vld && tree_valid) begin
        resp_valid_q[tail_id] <= 1'b1;
        resp_sum_q            <= tree_sum;
      end
      if (tail_vld != tree_valid) err_q <= 1'b1;
    end
  end

  // Flush FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StRun;
    else        state_q <= state_d;
  end

  // Flush FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush_req)  state_d = StDrain;
      StDrain: if (pipe_empty) state_d = StHold;
      StHold:  if (!flush_req) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  assign tree_vals  = tree_vals_q;
  assign tree_vi    = tree_vi_q;
  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign flush_done = (state_q == StHold);
  assign err        = err_q;

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// Testbench for adder_tree_scheduler: models the pipelined adder tree, keeps a scoreboard
// of expected responses, and runs one task per scenario.
module tb_adder_tree_scheduler;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned LATENCY = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           tree_vals;
  logic                  tree_vi;
  logic [6:0]            tree_sum;
  logic                  tree_valid;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [6:0]            resp_sum;
  logic                  flush_req;
  logic                  flush_done;
  logic                  err;
  logic                  force_tv;

  typedef struct packed {
    logic [NUM_REQ-1:0] onehot;
    logic [6:0]         sum;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  adder_tree_scheduler #(
    .NUM_REQ (NUM_REQ),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tree_vals  (tree_vals),
    .tree_vi    (tree_vi),
    .tree_sum   (tree_sum),
    .tree_valid (tree_valid),
    .resp_valid (resp_valid),
    .resp_sum   (resp_sum),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .err        (err)
  );

  // Adder tree model: LATENCY-deep pipeline sharing the block's reset.
  logic [6:0]         tm_sum_q [LATENCY];
  logic [LATENCY-1:0] tm_v_q;

  function automatic logic [6:0] nib_sum(input logic [31:0] v);
    logic [6:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + 7'(v[4*i +: 4]);
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm_v_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) tm_sum_q[i] <= '0;
    end else begin
      tm_v_q[0]   <= tree_vi;
      tm_sum_q[0] <= nib_sum(tree_vals);
      for (int i = 1; i < int'(LATENCY); i++) begin
        tm_v_q[i]   <= tm_v_q[i-1];
        tm_sum_q[i] <= tm_sum_q[i-1];
      end
    end
  end

  assign tree_valid = tm_v_q[LATENCY-1] | force_tv;
  assign tree_sum   = tm_sum_q[LATENCY-1];

  // Scoreboard monitor: every response must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid !== '0) begin
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_resp: got resp_valid=%b sum=%0d, required no response",
                 resp_valid, resp_sum);
      end else begin
        mon_e = sb_q.pop_front();
        if (resp_valid !== mon_e.onehot || resp_sum !== mon_e.sum)
          $display("FAIL resp: got valid=%b sum=%0d, required valid=%b sum=%0d",
                   resp_valid, resp_sum, mon_e.onehot, mon_e.sum);
        else n_pass++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    flush_req = 1'b0;
    force_tv  = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_sb_empty();
    int cnt;
    cnt = 0;
    while (sb_q.size() != 0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset();
    req_valid = '0;
    req_data  = '0;
    flush_req = 1'b0;
    force_tv  = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    n_total++;
    if ({req_ready, tree_vals, tree_vi, resp_valid, resp_sum, flush_done, err} !== '0)
      $display("FAIL reset_outputs: got ready=%b vals=%h vi=%b rv=%b sum=%0d fd=%b err=%b, required all 0",
               req_ready, tree_vals, tree_vi, resp_valid, resp_sum, flush_done, err);
    else n_pass++;
    req_valid = 2'b11;
    #1;
    n_total++;
    if (req_ready !== 2'b00) $display("FAIL reset_no_grant: got %b, required 00", req_ready);
    else n_pass++;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    n_total++;
    if (req_ready !== 2'b00 || tree_vi !== 1'b0 || flush_done !== 1'b0)
      $display("FAIL reset_idle: got ready=%b vi=%b fd=%b, required 00 0 0",
               req_ready, tree_vi, flush_done);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req_valid = 2'b01;
    req_data  = {32'h0, 32'h2298_7650};
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL single_grant: got %b, required 01", req_ready);
    else n_pass++;
    sb_q.push_back({2'b01, 7'd39});
    @(negedge clk);
    req_valid = '0;
    n_total++;
    if (tree_vi !== 1'b1 || tree_vals !== 32'h2298_7650)
      $display("FAIL single_issue: got vi=%b vals=%h, required 1 22987650", tree_vi, tree_vals);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (tree_vi !== 1'b0 || tree_vals !== 32'h2298_7650)
      $display("FAIL single_hold: got vi=%b vals=%h, required 0 22987650", tree_vi, tree_vals);
    else n_pass++;
    repeat (LATENCY - 1) @(negedge clk);
    n_total++;
    if (resp_valid !== 2'b00) $display("FAIL single_early: got %b, required 00", resp_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (resp_valid !== 2'b01 || resp_sum !== 7'd39)
      $display("FAIL single_resp: got rv=%b sum=%0d, required 01 39", resp_valid, resp_sum);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (resp_valid !== 2'b00 || resp_sum !== 7'd39)
      $display("FAIL single_sum_hold: got rv=%b sum=%0d, required 00 39", resp_valid, resp_sum);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
`ifndef SCHED_FIXED_PRIO_EN
    int exp_ptr;
    exp_ptr = 0;
`endif
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = 2'b11;
      req_data  = {32'hFFFF_FFFF, 32'h3333_3333};
      #1;
`ifdef SCHED_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g   = (exp_ptr == 0) ? 2'b01 : 2'b10;
      exp_ptr = 1 - exp_ptr;
`endif
      n_total++;
      if (req_ready !== exp_g)
        $display("FAIL arb_grant%0d: got %b, required %b", c, req_ready, exp_g);
      else n_pass++;
      sb_q.push_back({exp_g, exp_g[0] ? 7'd24 : 7'd120});
    end
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    n_total++;
    if (req_ready !== 2'b10) $display("FAIL arb_r1_alone: got %b, required 10", req_ready);
    else n_pass++;
    sb_q.push_back({2'b10, 7'd120});
    @(negedge clk);
    req_valid = '0;
    wait_sb_empty();
    n_total++;
    if (sb_q.size() != 0)
      $display("FAIL arb_drain: got %0d outstanding, required 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [3:0] nib;
    int         done_k;
    bit         bad_grant;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nib       = 4'(c + 1);
      req_valid = 2'b01;
      req_data  = {32'h0, {8{nib}}};
      #1;
      n_total++;
      if (req_ready !== 2'b01) $display("FAIL flush_pre%0d: got %b, required 01", c, req_ready);
      else n_pass++;
      sb_q.push_back({2'b01, 7'(8 * (c + 1))});
    end
    @(negedge clk);
    flush_req = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 2'b00) $display("FAIL flush_block: got %b, required 00", req_ready);
    else n_pass++;
    done_k    = 0;
    bad_grant = 1'b0;
    for (int k = 1; k <= int'(LATENCY) + 2; k++) begin
      @(negedge clk);
      #1;
      if (req_ready !== 2'b00) bad_grant = 1'b1;
      if (flush_done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    n_total++;
    if (done_k == 0) $display("FAIL flush_done: got none within %0d cycles, required 1", LATENCY + 2);
    else n_pass++;
    n_total++;
    if (bad_grant) $display("FAIL flush_grant: got a grant while draining, required none");
    else n_pass++;
    n_total++;
    if (sb_q.size() != 0)
      $display("FAIL flush_resps: got %0d outstanding at drain end, required 0", sb_q.size());
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (flush_done !== 1'b1 || req_ready !== 2'b00)
      $display("FAIL flush_hold: got fd=%b ready=%b, required 1 00", flush_done, req_ready);
    else n_pass++;
    @(negedge clk);
    flush_req = 1'b0;
    #1;
    n_total++;
    if (req_ready !== 2'b00) $display("FAIL flush_release_edge: got %b, required 00", req_ready);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (req_ready !== 2'b01 || flush_done !== 1'b0)
      $display("FAIL flush_resume: got ready=%b fd=%b, required 01 0", req_ready, flush_done);
    else n_pass++;
    sb_q.push_back({2'b01, 7'd24});
    @(negedge clk);
    req_valid = '0;
    wait_sb_empty();
    n_total++;
    if (sb_q.size() != 0)
      $display("FAIL flush_final: got %0d outstanding, required 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_error();
    do_reset();
    @(negedge clk);
    force_tv = 1'b1;
    #1;
    n_total++;
    if (err !== 1'b0) $display("FAIL err_pre: got %b, required 0", err);
    else n_pass++;
    @(negedge clk);
    force_tv = 1'b0;
    n_total++;
    if (err !== 1'b1) $display("FAIL err_set: got %b, required 1", err);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if (err !== 1'b1 || resp_valid !== 2'b00)
        $display("FAIL err_sticky%0d: got err=%b rv=%b, required 1 00", c, err, resp_valid);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (err !== 1'b0) $display("FAIL err_clear: got %b, required 0", err);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    @(negedge clk);
    req_valid = 2'b11;
    req_data  = {32'hFFFF_FFFF, 32'h3333_3333};
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL mid_grant0: got %b, required 01", req_ready);
    else n_pass++;
    sb_q.push_back({2'b01, 7'd24});
    @(negedge clk);
    #1;
    n_total++;
    if (req_ready !== 2'b10 && req_ready !== 2'b01)
      $display("FAIL mid_grant1: got %b, required one-hot", req_ready);
    else n_pass++;
    sb_q.push_back({req_ready, req_ready[0] ? 7'd24 : 7'd120});
    @(negedge clk);
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    sb_q.delete();
    n_total++;
    if ({req_ready, tree_vals, tree_vi, resp_valid, resp_sum, flush_done, err} !== '0)
      $display("FAIL mid_reset_outputs: got ready=%b vals=%h vi=%b rv=%b sum=%0d fd=%b err=%b, required all 0",
               req_ready, tree_vals, tree_vi, resp_valid, resp_sum, flush_done, err);
    else n_pass++;
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    for (int c = 0; c < int'(LATENCY) + 3; c++) begin
      @(negedge clk);
      n_total++;
      if (resp_valid !== 2'b00 || err !== 1'b0)
        $display("FAIL mid_stale%0d: got rv=%b err=%b, required 00 0", c, resp_valid, err);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_error();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
